// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields into 24-bit words and
// streams them through a small FIFO into instruction memory at consecutive addresses.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:5]        op,
  input  logic [0:1]        Rd,
  input  logic [0:1]        Rs,
  input  logic [0:1]        Rt,
  input  logic [0:11]       immediate,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:23]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t            state;
  logic [23:0]       fifo [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       occ;
  logic [ADDR_W-1:0] addr;
  logic              full, empty, push, pop;
  assign full      = occ == (PW+1)'(DEPTH);
  assign empty     = occ == '0;
  assign in_ready  = (state == LOAD) && !full;
  assign push      = in_valid && in_ready;
  assign mem_we    = !empty && (state == LOAD || state == DRAIN);
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = addr;
  // Empty FIFO reads as zero so the unreset storage never leaks onto the bus.
  assign mem_wdata = empty ? '0 : fifo[rp];
  always_ff @(posedge clk)
    if (push) fifo[wp] <= {op, Rd, Rs, Rt, immediate};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wp    <= '0;
      rp    <= '0;
      occ   <= '0;
      addr  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp   <= rp + 1'b1;
        addr <= addr + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end
      case (state)
        IDLE:
          if (start) begin
            state <= LOAD;
            addr  <= base_addr;
            count <= '0;
            busy  <= 1'b1;
          end
        LOAD:
          if (push && last) state <= DRAIN;
        DRAIN:
          if (empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
endmodule
